// File: rtl/score_entry_avg.sv
// Score entry block: assembles two-digit BCD scores and keeps a running sum and count.
// A subtractive divider produces the integer average.
module score_entry_avg #(
   parameter int MAX_SCORES = 15,
   parameter int CNT_W      = 4,
   parameter int SUM_W      = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       digit,
   input  logic             enter_btn,
   input  logic             clear_btn,
   input  logic             show_avg,
   output logic [6:0]       score,
   output logic             busy,
   output logic             tens_phase,
   output logic             err,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {
      GET_TENS = 2'd0,
      GET_ONES = 2'd1,
      DIVIDE   = 2'd2
   } state_t;

   // Button conditioning; bit 0 = enter, bit 1 = clear
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] prev_q, prev_d;
   logic [1:0] pulse_q, pulse_d;
   logic       enter_p;
   logic       clear_p;

   state_t           state_q, state_d;
   logic             div_init_q, div_init_d;
   logic [3:0]       tens_q, tens_d;
   logic [6:0]       last_q, last_d;
   logic [6:0]       avg_q, avg_d;
   logic [6:0]       quot_q, quot_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic [6:0]       score_q, score_d;

   logic [6:0]       last_calc;
   logic             digit_bad;
   logic             count_full;

   always_comb begin
      sync1_d = {clear_btn, enter_btn};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      pulse_d = sync2_q & ~prev_q;
   end

   assign enter_p = pulse_q[0];
   assign clear_p = pulse_q[1];

   assign last_calc  = ({3'b000, tens_q} * 7'd10) + {3'b000, digit};
   assign digit_bad  = (digit > 4'd9);
   assign count_full = (count_q == CNT_W'(MAX_SCORES));

   always_comb begin
      state_d    = state_q;
      div_init_d = div_init_q;
      tens_d     = tens_q;
      last_d     = last_q;
      avg_d      = avg_q;
      quot_d     = quot_q;
      sum_d      = sum_q;
      rem_d      = rem_q;
      count_d    = count_q;
      err_d      = 1'b0;

      if (clear_p) begin
         state_d    = GET_TENS;
         div_init_d = 1'b0;
         last_d     = '0;
         avg_d      = '0;
         quot_d     = '0;
         sum_d      = '0;
         rem_d      = '0;
         count_d    = '0;
      end else begin
         case (state_q)
            GET_TENS: begin
               if (enter_p) begin
                  if (digit_bad || count_full) begin
                     err_d = 1'b1;
                  end else begin
                     tens_d  = digit;
                     state_d = GET_ONES;
                  end
               end
            end
            GET_ONES: begin
               if (enter_p) begin
                  if (digit_bad) begin
                     err_d = 1'b1;
                  end else begin
                     last_d     = last_calc;
                     sum_d      = sum_q + SUM_W'(last_calc);
                     count_d    = count_q + CNT_W'(1);
                     div_init_d = 1'b1;
                     state_d    = DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               // First divide cycle loads the remainder from the freshly updated sum
               if (div_init_q) begin
                  rem_d      = sum_q;
                  quot_d     = '0;
                  div_init_d = 1'b0;
               end else if (rem_q >= SUM_W'(count_q)) begin
                  rem_d  = rem_q - SUM_W'(count_q);
                  quot_d = quot_q + 7'd1;
               end else begin
                  avg_d   = quot_q;
                  state_d = GET_TENS;
               end
            end
            default: begin
               state_d = GET_TENS;
            end
         endcase
      end
   end

   // Score is frozen for the whole divide so the display never shows a partial result
   always_comb begin
      score_d = show_avg ? avg_q : last_q;
      if (state_q == DIVIDE) begin
         score_d = score_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         pulse_q    <= '0;
         state_q    <= GET_TENS;
         div_init_q <= 1'b0;
         tens_q     <= '0;
         last_q     <= '0;
         avg_q      <= '0;
         quot_q     <= '0;
         sum_q      <= '0;
         rem_q      <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         score_q    <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         pulse_q    <= pulse_d;
         state_q    <= state_d;
         div_init_q <= div_init_d;
         tens_q     <= tens_d;
         last_q     <= last_d;
         avg_q      <= avg_d;
         quot_q     <= quot_d;
         sum_q      <= sum_d;
         rem_q      <= rem_d;
         count_q    <= count_d;
         err_q      <= err_d;
         score_q    <= score_d;
      end
   end

   assign score      = score_q;
   assign busy       = (state_q == DIVIDE);
   assign tens_phase = (state_q == GET_TENS);
   assign err        = err_q;
   assign count      = count_q;

endmodule

// File: tb/tb_score_entry_avg.sv
// Bench for score_entry_avg: scoreboard of expected last/average/count/divide length per entry.
module tb_score_entry_avg;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] digit;
   logic       enter_btn;
   logic       clear_btn;
   logic       show_avg;
   logic [6:0] score;
   logic       busy;
   logic       tens_phase;
   logic       err;
   logic [3:0] count;

   score_entry_avg dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .digit      (digit),
      .enter_btn  (enter_btn),
      .clear_btn  (clear_btn),
      .show_avg   (show_avg),
      .score      (score),
      .busy       (busy),
      .tens_phase (tens_phase),
      .err        (err),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int last;
      int avg;
      int cnt;
      int bcyc;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;
   int sum_m = 0;
   int cnt_m = 0;
   int last_m = 0;

   // Press and release enter with a digit; returns busy length, err pulses, score seen mid-divide
   task automatic key(input int d, output int bcyc, output int errs, output int hold);
      bcyc = 0;
      errs = 0;
      hold = -1;
      @(negedge clk);
      digit = 4'(d);
      enter_btn = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 5) enter_btn = 1'b0;
         if (err) errs++;
         if (busy) begin
            bcyc++;
            if (bcyc == 5) hold = int'(score);
         end else if (i >= 8) begin
            break;
         end
      end
      enter_btn = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL key_timeout: busy=%b required 0", busy);
      end
   endtask

   task automatic clear_all();
      @(negedge clk);
      clear_btn = 1'b1;
      repeat (5) @(negedge clk);
      clear_btn = 1'b0;
      repeat (3) @(negedge clk);
      sum_m = 0;
      cnt_m = 0;
      last_m = 0;
      sb.delete();
   endtask

   task automatic enter_score(input int v);
      int b, e, h, last_prev;
      exp_t ex;
      key(v / 10, b, e, h);
      vectors++;
      if (tens_phase !== 1'b0 || e != 0) begin
         miscompares++;
         $display("FAIL tens_accept(%0d): tens_phase=%b errs=%0d required 0/0", v, tens_phase, e);
      end
      last_prev = last_m;
      cnt_m++;
      sum_m += v;
      last_m = v;
      ex.last = v;
      ex.avg = sum_m / cnt_m;
      ex.cnt = cnt_m;
      ex.bcyc = sum_m / cnt_m + 2;
      sb.push_back(ex);
      key(v % 10, b, e, h);
      ex = sb.pop_front();
      vectors++;
      if (b != ex.bcyc) begin
         miscompares++;
         $display("FAIL busy_len(%0d): got %0d required %0d", v, b, ex.bcyc);
      end
      if (ex.bcyc >= 5) begin
         vectors++;
         if (h != last_prev) begin
            miscompares++;
            $display("FAIL score_hold(%0d): got %0d required %0d", v, h, last_prev);
         end
      end
      vectors++;
      if (count !== 4'(ex.cnt) || tens_phase !== 1'b1 || e != 0) begin
         miscompares++;
         $display("FAIL entry_state(%0d): count=%0d tens_phase=%b errs=%0d required %0d/1/0",
                  v, count, tens_phase, e, ex.cnt);
      end
      show_avg = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (score !== 7'(ex.last)) begin
         miscompares++;
         $display("FAIL score_last(%0d): got %0d required %0d", v, score, ex.last);
      end
      show_avg = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (score !== 7'(ex.avg)) begin
         miscompares++;
         $display("FAIL score_avg(%0d): got %0d required %0d", v, score, ex.avg);
      end
      show_avg = 1'b0;
      repeat (2) @(negedge clk);
      $display("entry %0d: count=%0d avg=%0d busy_cycles=%0d", v, count, ex.avg, b);
   endtask

   task automatic test_reset();
      int errs = 0;
      reset_n = 1'b0;
      digit = 4'd0;
      show_avg = 1'b0;
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         enter_btn = ~enter_btn;
         clear_btn = (i % 3) == 0;
         if (err) errs++;
      end
      enter_btn = 1'b0;
      clear_btn = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (err) errs++;
      end
      vectors++;
      if (score !== 7'd0 || count !== 4'd0 || busy !== 1'b0 || tens_phase !== 1'b1 || errs != 0) begin
         miscompares++;
         $display("FAIL reset: score=%0d count=%0d busy=%b tens_phase=%b errs=%0d required 0/0/0/1/0",
                  score, count, busy, tens_phase, errs);
      end
      $display("reset: score=%0d count=%0d", score, count);
   endtask

   task automatic test_single();
      enter_score(87);
   endtask

   task automatic test_average();
      clear_all();
      enter_score(90);
      enter_score(61);
      enter_score(50);
   endtask

   task automatic test_invalid();
      int b, e, h;
      exp_t ex;
      clear_all();
      key(12, b, e, h);
      vectors++;
      if (e != 1 || tens_phase !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_tens: errs=%0d tens_phase=%b required 1/1", e, tens_phase);
      end
      key(9, b, e, h);
      vectors++;
      if (e != 0 || tens_phase !== 1'b0) begin
         miscompares++;
         $display("FAIL good_tens: errs=%0d tens_phase=%b required 0/0", e, tens_phase);
      end
      key(12, b, e, h);
      vectors++;
      if (e != 1 || tens_phase !== 1'b0 || b != 0) begin
         miscompares++;
         $display("FAIL bad_ones: errs=%0d tens_phase=%b busy=%0d required 1/0/0", e, tens_phase, b);
      end
      cnt_m++;
      sum_m += 95;
      last_m = 95;
      ex.last = 95;
      ex.avg = sum_m / cnt_m;
      ex.cnt = cnt_m;
      ex.bcyc = ex.avg + 2;
      sb.push_back(ex);
      key(5, b, e, h);
      ex = sb.pop_front();
      repeat (2) @(negedge clk);
      vectors++;
      if (score !== 7'(ex.last) || count !== 4'(ex.cnt) || b != ex.bcyc) begin
         miscompares++;
         $display("FAIL kept_tens: score=%0d count=%0d busy=%0d required %0d/%0d/%0d",
                  score, count, b, ex.last, ex.cnt, ex.bcyc);
      end
      $display("invalid digits: last=%0d", score);
   endtask

   task automatic test_full();
      int b, e, h;
      clear_all();
      for (int i = 0; i < 15; i++) enter_score(99);
      key(9, b, e, h);
      show_avg = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (e != 1 || count !== 4'd15 || tens_phase !== 1'b1 || score !== 7'd99) begin
         miscompares++;
         $display("FAIL full: errs=%0d count=%0d tens_phase=%b score=%0d required 1/15/1/99",
                  e, count, tens_phase, score);
      end
      show_avg = 1'b0;
      $display("full: count=%0d rejected 16th", count);
   endtask

   task automatic test_clear_mid_divide();
      int b, e, h, drop, errs;
      clear_all();
      key(8, b, e, h);
      @(negedge clk);
      digit = 4'd0;
      enter_btn = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL divide_start: busy=%b required 1", busy);
      end
      enter_btn = 1'b0;
      repeat (3) @(negedge clk);
      clear_btn = 1'b1;
      enter_btn = 1'b1;
      digit = 4'd5;
      drop = -1;
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (err) errs++;
         if (!busy) begin
            drop = i;
            break;
         end
      end
      vectors++;
      if (drop < 2 || drop > 4) begin
         miscompares++;
         $display("FAIL clear_latency: got %0d required 2..4", drop);
      end
      repeat (3) begin
         @(negedge clk);
         if (err) errs++;
      end
      clear_btn = 1'b0;
      enter_btn = 1'b0;
      vectors++;
      if (count !== 4'd0 || tens_phase !== 1'b1 || score !== 7'd0 || errs != 0) begin
         miscompares++;
         $display("FAIL clear_state: count=%0d tens_phase=%b score=%0d errs=%0d required 0/1/0/0",
                  count, tens_phase, score, errs);
      end
      show_avg = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (score !== 7'd0) begin
         miscompares++;
         $display("FAIL clear_avg: got %0d required 0", score);
      end
      show_avg = 1'b0;
      repeat (2) @(negedge clk);
      $display("clear mid-divide: busy dropped after %0d cycles", drop + 1);
      sum_m = 0;
      cnt_m = 0;
      last_m = 0;
      enter_score(42);
   endtask

   task automatic test_reset_mid_divide();
      int b, e, h;
      clear_all();
      key(5, b, e, h);
      @(negedge clk);
      digit = 4'd5;
      enter_btn = 1'b1;
      repeat (6) @(negedge clk);
      enter_btn = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_div_start: busy=%b required 1", busy);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || count !== 4'd0 || tens_phase !== 1'b1 || score !== 7'd0) begin
         miscompares++;
         $display("FAIL rst_mid_divide: busy=%b count=%0d tens_phase=%b score=%0d required 0/0/1/0",
                  busy, count, tens_phase, score);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      sum_m = 0;
      cnt_m = 0;
      last_m = 0;
      $display("reset mid-divide: count=%0d", count);
      enter_score(33);
   endtask

   initial begin
      test_reset();
      test_single();
      test_average();
      test_invalid();
      test_full();
      test_clear_mid_divide();
      test_reset_mid_divide();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

endmodule
